// File: rtl/tdm_demux_1x4_if.sv
// Serial TDM link and parallel per-channel outputs of the 1:4 demultiplexer.
// Pure wiring, no latency of its own.
// No backpressure: the link side only qualifies beats with din_valid.
interface tdm_demux_1x4_if #(
   parameter int W = 8
);
   logic [W-1:0] din;
   logic         din_valid;
   logic         sof;
   logic [W-1:0] o0;
   logic [W-1:0] o1;
   logic [W-1:0] o2;
   logic [W-1:0] o3;
   logic         frame_valid;
   logic [1:0]   slot;
   logic         sync_err;

   // Link driver / consumer side
   modport master (
      output din, din_valid, sof,
      input  o0, o1, o2, o3, frame_valid, slot, sync_err
   );

   // Demultiplexer side
   modport slave (
      input  din, din_valid, sof,
      output o0, o1, o2, o3, frame_valid, slot, sync_err
   );
endinterface

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demux: rebuilds a 4-slot frame in shadow registers, commits it atomically to o0..o3.
// Latency: outputs and frame_valid appear one cycle after the slot-3 beat.
// No backpressure: every valid beat is consumed; din_valid low simply stalls the frame.
module tdm_demux_1x4 #(
   parameter int W = 8
) (
   input logic            clk,
   input logic            rst,
   tdm_demux_1x4_if.slave link
);
   typedef enum logic {HUNT, RECV} state_t;

   state_t         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [W-1:0]   s0_q, s1_q, s2_q;
   logic [W-1:0]   s0_d, s1_d, s2_d;
   logic [W-1:0]   o0_q, o1_q, o2_q, o3_q;
   logic [W-1:0]   o0_d, o1_d, o2_d, o3_d;
   logic           fv_q, fv_d;
   logic           err_q, err_d;

   // Register all frame state; reset discards any partial frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUNT;
         cnt_q   <= 2'd0;
         s0_q    <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         o0_q    <= '0;
         o1_q    <= '0;
         o2_q    <= '0;
         o3_q    <= '0;
         fv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         o0_q    <= o0_d;
         o1_q    <= o1_d;
         o2_q    <= o2_d;
         o3_q    <= o3_d;
         fv_q    <= fv_d;
         err_q   <= err_d;
      end
   end

   // Next-state: collect slots into shadows, commit on slot 3, flag framing errors
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      o0_d    = o0_q;
      o1_d    = o1_q;
      o2_d    = o2_q;
      o3_d    = o3_q;
      fv_d    = 1'b0;
      err_d   = 1'b0;
      if (link.din_valid) begin
         case (state_q)
            HUNT: begin
               if (link.sof) begin
                  s0_d    = link.din;
                  cnt_d   = 2'd1;
                  state_d = RECV;
               end else begin
                  // Beat outside any frame: drop it
                  err_d = 1'b1;
               end
            end
            RECV: begin
               if (link.sof) begin
                  // Early sof restarts the frame with this beat as slot 0
                  err_d = 1'b1;
                  s0_d  = link.din;
                  cnt_d = 2'd1;
               end else begin
                  case (cnt_q)
                     2'd1: begin
                        s1_d  = link.din;
                        cnt_d = 2'd2;
                     end
                     2'd2: begin
                        s2_d  = link.din;
                        cnt_d = 2'd3;
                     end
                     2'd3: begin
                        o0_d    = s0_q;
                        o1_d    = s1_q;
                        o2_d    = s2_q;
                        o3_d    = link.din;
                        fv_d    = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = HUNT;
                     end
                     default: begin
                        // cnt is never 0 while in RECV; fall back to hunting
                        state_d = HUNT;
                     end
                  endcase
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // Drive the registered outputs onto the interface
   assign link.o0          = o0_q;
   assign link.o1          = o1_q;
   assign link.o2          = o2_q;
   assign link.o3          = o3_q;
   assign link.frame_valid = fv_q;
   assign link.sync_err    = err_q;
   assign link.slot        = cnt_q;
endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Table-driven bench for tdm_demux_1x4 with a frame scoreboard.
// Each row is one clock: inputs plus the outputs expected in the following cycle.
// Committed frames are queued when driven and popped on frame_valid.
module tb_tdm_demux_1x4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tdm_demux_1x4_if #(.W(W)) link ();

   tdm_demux_1x4 #(.W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link.slave)
   );

   typedef struct packed {
      logic        r;
      logic        vld;
      logic        sof;
      logic [7:0]  din;
      logic        fv;
      logic        err;
      logic [1:0]  slot;
      logic [31:0] o;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] sb[$];
   int          errors = 0;
   int          checks = 0;

   task automatic add(input logic r, input logic vld, input logic sof, input logic [7:0] d,
                      input logic fv, input logic err, input logic [1:0] sl, input logic [31:0] o);
      vec_t v;
      v.r = r; v.vld = vld; v.sof = sof; v.din = d;
      v.fv = fv; v.err = err; v.slot = sl; v.o = o;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
      end
   endtask

   initial begin
      logic [31:0] cur;
      logic [31:0] frm;
      logic [31:0] got;

      rst = 1'b1;
      link.din_valid = 1'b0;
      link.sof = 1'b0;
      link.din = '0;

      // Reset then clean frame
      add(1,0,0,8'h00, 0,0,0, 32'h0);
      add(1,0,0,8'h00, 0,0,0, 32'h0);
      add(0,1,1,8'h11, 0,0,1, 32'h0);
      add(0,1,0,8'h22, 0,0,2, 32'h0);
      add(0,1,0,8'h33, 0,0,3, 32'h0);
      add(0,1,0,8'h44, 1,0,0, 32'h11223344);
      add(0,0,1,8'hEE, 0,0,0, 32'h11223344);   // sof ignored while din_valid low

      // Stalled frame from a cleared state, 3-cycle gaps
      add(1,0,0,8'h00, 0,0,0, 32'h0);
      add(0,1,1,8'h11, 0,0,1, 32'h0);
      for (int g = 0; g < 3; g++) add(0,0,0,8'hA5, 0,0,1, 32'h0);
      add(0,1,0,8'h22, 0,0,2, 32'h0);
      for (int g = 0; g < 3; g++) add(0,0,0,8'hA5, 0,0,2, 32'h0);
      add(0,1,0,8'h33, 0,0,3, 32'h0);
      for (int g = 0; g < 3; g++) add(0,0,0,8'hA5, 0,0,3, 32'h0);
      add(0,1,0,8'h44, 1,0,0, 32'h11223344);
      add(0,0,0,8'h00, 0,0,0, 32'h11223344);

      // Premature sof abandons the A frame
      add(0,1,1,8'hA0, 0,0,1, 32'h11223344);
      add(0,1,0,8'hA1, 0,0,2, 32'h11223344);
      add(0,1,1,8'hB0, 0,1,1, 32'h11223344);
      add(0,1,0,8'hB1, 0,0,2, 32'h11223344);
      add(0,1,0,8'hB2, 0,0,3, 32'h11223344);
      add(0,1,0,8'hB3, 1,0,0, 32'hB0B1B2B3);

      // Hunt drop after reset
      add(1,0,0,8'h00, 0,0,0, 32'h0);
      add(0,1,0,8'h55, 0,1,0, 32'h0);
      add(0,1,1,8'h01, 0,0,1, 32'h0);
      add(0,1,0,8'h02, 0,0,2, 32'h0);
      add(0,1,0,8'h03, 0,0,3, 32'h0);
      add(0,1,0,8'h04, 1,0,0, 32'h01020304);

      // Reset mid-frame: partial 0x99 frame is lost, stray beat after reset is dropped
      add(0,1,1,8'h11, 0,0,1, 32'h01020304);
      add(0,1,0,8'h22, 0,0,2, 32'h01020304);
      add(0,1,0,8'h33, 0,0,3, 32'h01020304);
      add(0,1,0,8'h44, 1,0,0, 32'h11223344);
      add(0,1,1,8'h99, 0,0,1, 32'h11223344);
      add(0,1,0,8'h98, 0,0,2, 32'h11223344);
      add(1,1,0,8'h97, 0,0,0, 32'h0);          // reset wins over the valid beat
      add(0,1,0,8'h96, 0,1,0, 32'h0);
      add(0,1,1,8'h61, 0,0,1, 32'h0);
      add(0,1,0,8'h62, 0,0,2, 32'h0);
      add(0,1,0,8'h63, 0,0,3, 32'h0);
      add(0,1,0,8'h64, 1,0,0, 32'h61626364);

      // Continuous stream: 3 frames, 12 back-to-back beats
      cur = 32'h61626364;
      for (int f = 0; f < 3; f++) begin
         frm = '0;
         for (int b = 0; b < 4; b++) begin
            logic [7:0] d;
            d = 8'(8'h10 + f * 4 + b);
            frm = {frm[23:0], d};
            if (b == 3) cur = frm;
            add(0, 1, (b == 0), d, (b == 3), 0, 2'((b + 1) % 4), cur);
         end
      end
      add(0,0,0,8'h00, 0,0,0, cur);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst            = vecs[i].r;
         link.din_valid = vecs[i].vld;
         link.sof       = vecs[i].sof;
         link.din       = vecs[i].din;
         if (vecs[i].fv) sb.push_back(vecs[i].o);
         @(posedge clk);
         #1;
         got = {link.o0, link.o1, link.o2, link.o3};
         chk("frame_valid", i, 32'(link.frame_valid), 32'(vecs[i].fv));
         chk("sync_err",    i, 32'(link.sync_err),    32'(vecs[i].err));
         chk("slot",        i, 32'(link.slot),        32'(vecs[i].slot));
         chk("outputs",     i, got,                   vecs[i].o);
         if (link.frame_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected row %0d: got frame %h want none", i, got);
            end else begin
               chk("sb_frame", i, got, sb.pop_front());
            end
         end
      end
      chk("sb_empty", vecs.size(), 32'(sb.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
